pc_sequencer: RTL and testbench

//  Multi-cycle control sequencer for the 32-bit single-issue core. Owns the PC, latches the word read

---
 rtl/hc_isa_pkg.sv | 35 +++
 rtl/pc_sequencer_if.sv | 22 ++
 rtl/pc_next_select.sv | 21 ++
 rtl/pc_sequencer.sv | 53 +++++
 tb/tb_pc_sequencer.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/hc_isa_pkg.sv
// hc_isa_pkg: opcodes, ALU and write-back select codes, and sequencer states shared by the core.
package hc_isa_pkg;
  localparam logic [5:0] OP_NOP = 6'h00, OP_ADD = 6'h01, OP_SUB = 6'h02, OP_LW = 6'h03,
                         OP_MOV = 6'h04, OP_SW = 6'h05, OP_LI = 6'h06, OP_AND = 6'h07,
                         OP_OR = 6'h08, OP_NOT = 6'h09, OP_XOR = 6'h0a, OP_SRL = 6'h0b,
                         OP_SLL = 6'h0c, OP_BEQ = 6'h0d, OP_BNE = 6'h0e, OP_BGT = 6'h0f,
                         OP_J = 6'h11, OP_JR = 6'h12, OP_IN = 6'h13, OP_OUT = 6'h14,
                         OP_HALT = 6'h3f;
  localparam logic [3:0] ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                         ALU_OR = 4'd4, ALU_NOT = 4'd5, ALU_XOR = 4'd6, ALU_SRL = 4'd7,
                         ALU_SLL = 4'd8, ALU_PASS = 4'd9, ALU_CMP = 4'd10;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_IMM = 2'd2, WB_IN = 2'd3;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WAIT_IN, WAIT_OUT, HALT} state_t;
  function automatic logic legal(input logic [5:0] op);
    return op <= OP_BGT || (op >= OP_J && op <= OP_OUT) || op == OP_HALT;
  endfunction
  function automatic logic alu_writes(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SRL, OP_SLL, OP_MOV, OP_LI};
  endfunction
  function automatic logic [3:0] alu_code(input logic [5:0] op);
    case (op)
      OP_ADD: return ALU_ADD;
      OP_SUB: return ALU_SUB;
      OP_AND: return ALU_AND;
      OP_OR: return ALU_OR;
      OP_NOT: return ALU_NOT;
      OP_XOR: return ALU_XOR;
      OP_SRL: return ALU_SRL;
      OP_SLL: return ALU_SLL;
      OP_MOV: return ALU_PASS;
      OP_BEQ, OP_BNE, OP_BGT: return ALU_CMP;
      default: return ALU_NONE;
    endcase
  endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch, control and handshake signals between the sequencer and the datapath.
interface pc_sequencer_if #(parameter int PC_WIDTH = 32, parameter int ALUOP_W = 4);
  logic [31:0] instruction;
  logic [PC_WIDTH-1:0] pc;
  logic [31:0] ir;
  logic reg_write;
  logic [1:0] wb_sel;
  logic [ALUOP_W-1:0] alu_op;
  logic mem_read, mem_write, mem_ack;
  logic cmp_eq, cmp_gt;
  logic [PC_WIDTH-1:0] reg_target;
  logic in_valid, in_ready, out_valid, out_ack;
  logic halted, illegal_op;
  modport master (
    input instruction, mem_ack, cmp_eq, cmp_gt, reg_target, in_valid, out_ack,
    output pc, ir, reg_write, wb_sel, alu_op, mem_read, mem_write, in_ready, out_valid, halted, illegal_op
  );
  modport slave (
    output instruction, mem_ack, cmp_eq, cmp_gt, reg_target, in_valid, out_ack,
    input pc, ir, reg_write, wb_sel, alu_op, mem_read, mem_write, in_ready, out_valid, halted, illegal_op
  );
endinterface

// File: rtl/pc_next_select.sv
// pc_next_select: next fetch address for the instruction in IR, wrapped to the instruction memory depth.
module pc_next_select import hc_isa_pkg::*; #(
  parameter int PC_WIDTH = 32,
  parameter int IMEM_DEPTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [31:0]         ir,
  input  logic                cmp_eq,
  input  logic                cmp_gt,
  input  logic [PC_WIDTH-1:0] reg_target,
  output logic [PC_WIDTH-1:0] next_pc
);
  localparam logic [PC_WIDTH-1:0] MASK = PC_WIDTH'(IMEM_DEPTH - 1);
  logic [5:0] op;
  logic taken;
  always_comb begin
    op = ir[31:26];
    taken = (op == OP_BEQ && cmp_eq) || (op == OP_BNE && !cmp_eq) || (op == OP_BGT && cmp_gt) || op == OP_JR;
    next_pc = MASK & (taken ? reg_target : op == OP_J ? PC_WIDTH'(ir[25:0]) : pc + 1'b1);
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/decode/execute control FSM with memory and I/O handshake stalls.
module pc_sequencer import hc_isa_pkg::*; #(
  parameter int PC_WIDTH = 32,
  parameter int IMEM_DEPTH = 32,
  parameter int ALUOP_W = 4
) (
  input logic clk,
  input logic rst,
  pc_sequencer_if.master bus
);
  state_t state, next_state;
  logic [PC_WIDTH-1:0] pc, next_pc;
  logic [31:0] ir;
  logic [5:0] op;
  logic leave;
  assign op = ir[31:26];
  assign bus.pc = pc;
  assign bus.ir = ir;
  pc_next_select #(.PC_WIDTH(PC_WIDTH), .IMEM_DEPTH(IMEM_DEPTH)) u_next (
    .pc(pc), .ir(ir), .cmp_eq(bus.cmp_eq), .cmp_gt(bus.cmp_gt), .reg_target(bus.reg_target), .next_pc(next_pc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= '0;
      ir <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH) ir <= bus.instruction;
      if (leave) pc <= next_pc;
    end
  end
  // leave marks the single cycle per instruction in which PC advances
  always_comb begin
    leave = state == EXEC || (state == MEM && bus.mem_ack) || (state == WAIT_IN && bus.in_valid) ||
            (state == WAIT_OUT && bus.out_ack);
    next_state = state == FETCH ? DECODE :
                 state == DECODE ? ((op == OP_LW || op == OP_SW) ? MEM : op == OP_IN ? WAIT_IN :
                                    op == OP_OUT ? WAIT_OUT : op == OP_HALT ? HALT : EXEC) :
                 state == HALT ? HALT : leave ? FETCH : state;
    bus.reg_write = (state == EXEC && alu_writes(op)) || (state == MEM && op == OP_LW && bus.mem_ack) ||
                    (state == WAIT_IN && bus.in_valid);
    bus.wb_sel = state == WAIT_IN ? WB_IN : (state == MEM && op == OP_LW) ? WB_MEM :
                 (state == EXEC && op == OP_LI) ? WB_IMM : WB_ALU;
    bus.alu_op = state == EXEC ? ALUOP_W'(alu_code(op)) : '0;
    bus.mem_read = state == MEM && op == OP_LW;
    bus.mem_write = state == MEM && op == OP_SW;
    bus.in_ready = state == WAIT_IN;
    bus.out_valid = state == WAIT_OUT;
    bus.halted = state == HALT;
    bus.illegal_op = state == DECODE && !legal(op);
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed table, hand-written corner sequences and random instructions against a per-instruction model.
module tb_pc_sequencer;
  import hc_isa_pkg::*;
  localparam int DEPTH = 32;
  typedef struct {
    logic [5:0]  op;
    logic [25:0] imm;
    bit          eq;
    bit          gt;
    logic [31:0] tgt;
    int          w;
    logic [31:0] exp_pc;
  } vec_t;
  logic clk = 0, rst = 1;
  int tests = 0, fails = 0;
  logic [31:0] pc_m = 0;
  vec_t vecs[$];
  pc_sequencer_if #(.PC_WIDTH(32), .ALUOP_W(4)) bus();
  pc_sequencer #(.PC_WIDTH(32), .IMEM_DEPTH(DEPTH), .ALUOP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal_m(input logic [5:0] op);
    return op inside {[6'd0:6'd15], [6'd17:6'd20], 6'd63};
  endfunction
  function automatic bit writes_m(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SRL, OP_SLL, OP_MOV, OP_LI};
  endfunction
  function automatic int alu_m(input logic [5:0] op);
    return op == OP_ADD ? int'(ALU_ADD) : op == OP_SUB ? int'(ALU_SUB) : op == OP_AND ? int'(ALU_AND) :
           op == OP_OR ? int'(ALU_OR) : op == OP_XOR ? int'(ALU_XOR) : op == OP_NOT ? int'(ALU_NOT) :
           op == OP_MOV ? int'(ALU_PASS) : -1;
  endfunction
  function automatic logic [31:0] next_pc_m(input logic [5:0] op, input logic [25:0] imm, input bit eq, input bit gt,
                                            input logic [31:0] tgt, input logic [31:0] pc);
    if ((op == OP_BEQ && eq) || (op == OP_BNE && !eq) || (op == OP_BGT && gt) || op == OP_JR) return tgt % DEPTH;
    if (op == OP_J) return 32'(imm) % DEPTH;
    return (pc + 1) % DEPTH;
  endfunction
  function automatic logic [31:0] ctl();
    return 32'({bus.halted, bus.reg_write, bus.mem_read, bus.mem_write, bus.in_ready, bus.out_valid,
                bus.illegal_op, bus.wb_sel, bus.alu_op});
  endfunction

  task automatic add_vec(input logic [5:0] op, input logic [25:0] imm, input bit eq, input bit gt,
                         input logic [31:0] tgt, input int w, input logic [31:0] exp_pc);
    vec_t v;
    v.op = op; v.imm = imm; v.eq = eq; v.gt = gt; v.tgt = tgt; v.w = w; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endtask

  task automatic run_instr(input logic [31:0] instr, input bit eq, input bit gt, input logic [31:0] tgt,
                           input int w, input logic [31:0] exp_pc);
    logic [5:0] op;
    bit is_mem, is_in, is_out, stall, rw;
    int n;
    logic [5:0] exp_vec;
    op = instr[31:26];
    is_mem = op == OP_LW || op == OP_SW;
    is_in = op == OP_IN;
    is_out = op == OP_OUT;
    stall = is_mem || is_in || is_out;
    n = stall ? 3 + w : 3;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      bus.instruction = instr; bus.cmp_eq = eq; bus.cmp_gt = gt; bus.reg_target = tgt;
      bus.mem_ack = (is_mem && k >= 3) ? (k == n) : 1'($urandom);
      bus.in_valid = (is_in && k >= 3) ? (k == n) : 1'($urandom);
      bus.out_ack = (is_out && k >= 3) ? (k == n) : 1'($urandom);
      #1;
      rw = k >= 3 && ((!stall && writes_m(op)) || (k == n && (op == OP_LW || op == OP_IN)));
      exp_vec = {rw, op == OP_LW && k >= 3, op == OP_SW && k >= 3, is_in && k >= 3, is_out && k >= 3,
                 k == 2 && !is_legal_m(op)};
      check($sformatf("ctl op%0h c%0d", op, k),
            32'({bus.reg_write, bus.mem_read, bus.mem_write, bus.in_ready, bus.out_valid, bus.illegal_op}),
            32'(exp_vec));
      check("halted_low", 32'(bus.halted), 0);
      check("pc_hold", bus.pc, pc_m);
      if (rw) check("wb_sel", 32'(bus.wb_sel), op == OP_LI ? 2 : op == OP_LW ? 1 : op == OP_IN ? 3 : 0);
      if (k == 2) check("ir", bus.ir, instr);
      if (k == 3 && alu_m(op) >= 0) check("alu_op", 32'(bus.alu_op), 32'(alu_m(op)));
    end
    @(posedge clk); #1;
    check($sformatf("pc_next op%0h", op), bus.pc, exp_pc);
    pc_m = exp_pc;
  endtask

  task automatic cyc(input logic [31:0] instr, input bit ack);
    @(negedge clk);
    bus.instruction = instr; bus.mem_ack = ack; bus.in_valid = ack; bus.out_ack = ack;
    #1;
  endtask

  task automatic reset_check(input string name);
    @(negedge clk);
    rst = 1; bus.mem_ack = 1; bus.in_valid = 1; bus.out_ack = 1;
    @(posedge clk); #1;
    check({name, "_pc"}, bus.pc, 0);
    check({name, "_ir"}, bus.ir, 0);
    check({name, "_ctl"}, ctl(), 0);
    rst = 0;
    pc_m = 0;
  endtask

  initial begin
    logic [31:0] instr, tgt, exp;
    logic [5:0] op;
    bit eq, gt;
    int w;
    bus.instruction = 0; bus.mem_ack = 0; bus.cmp_eq = 0; bus.cmp_gt = 0;
    bus.reg_target = 0; bus.in_valid = 0; bus.out_ack = 0;
    add_vec(OP_LI,   26'd1,  0, 0, 32'd0,  0, 32'd1);
    add_vec(OP_BGT,  26'd0,  0, 1, 32'd10, 0, 32'd10);
    add_vec(OP_BGT,  26'd0,  0, 0, 32'd10, 0, 32'd11);
    add_vec(OP_BEQ,  26'd0,  1, 0, 32'd37, 0, 32'd5);
    add_vec(OP_BNE,  26'd0,  1, 0, 32'd0,  0, 32'd6);
    add_vec(OP_BNE,  26'd0,  0, 0, 32'd20, 0, 32'd20);
    add_vec(OP_J,    26'd14, 0, 0, 32'd3,  0, 32'd14);
    add_vec(OP_JR,   26'd2,  0, 0, 32'd31, 0, 32'd31);
    add_vec(OP_NOP,  26'd0,  1, 1, 32'd7,  0, 32'd0);
    add_vec(OP_LW,   26'd5,  0, 0, 32'd0,  4, 32'd1);
    add_vec(OP_SW,   26'd5,  0, 0, 32'd0,  0, 32'd2);
    add_vec(OP_IN,   26'd0,  0, 0, 32'd0,  3, 32'd3);
    add_vec(OP_OUT,  26'd0,  0, 0, 32'd0,  0, 32'd4);
    add_vec(6'h10,   26'd9,  0, 0, 32'd0,  0, 32'd5);
    add_vec(OP_ADD,  26'd0,  0, 0, 32'd0,  0, 32'd6);
    add_vec(OP_MOV,  26'd0,  0, 0, 32'd0,  0, 32'd7);
    add_vec(OP_SUB,  26'd0,  1, 1, 32'd25, 0, 32'd8);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", bus.pc, 0);
    check("rst_ir", bus.ir, 0);
    check("rst_ctl", ctl(), 0);
    rst = 0;
    foreach (vecs[i])
      run_instr({vecs[i].op, vecs[i].imm}, vecs[i].eq, vecs[i].gt, vecs[i].tgt, vecs[i].w, vecs[i].exp_pc);
    for (int i = 0; i < 80; i++) begin
      op = 6'($urandom_range(0, 62));
      instr = {op, 26'($urandom)};
      eq = 1'($urandom); gt = 1'($urandom); tgt = $urandom;
      w = $urandom_range(0, 4);
      exp = next_pc_m(op, instr[25:0], eq, gt, tgt, pc_m);
      run_instr(instr, eq, gt, tgt, w, exp);
    end
    for (int k = 1; k <= 10; k++) begin
      cyc({OP_HALT, 26'd4}, 1'($urandom));
      check("halt_pc", bus.pc, pc_m);
      check($sformatf("halt_ctl c%0d", k), 32'({bus.halted, bus.reg_write, bus.mem_read, bus.mem_write,
            bus.in_ready, bus.out_valid}), k >= 3 ? 32'h20 : 32'h0);
    end
    reset_check("rst_halt");
    run_instr({OP_J, 26'd9}, 0, 0, 0, 0, 32'd9);
    for (int k = 1; k <= 6; k++) begin
      cyc({OP_LW, 26'd0}, k < 3 ? 1'($urandom) : 1'b0);
      check($sformatf("stall_rd c%0d", k), 32'({bus.mem_read, bus.reg_write}), k >= 3 ? 32'h2 : 32'h0);
      check("stall_pc", bus.pc, 9);
    end
    reset_check("rst_stall");
    run_instr({OP_LI, 26'd1}, 0, 0, 0, 0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
